// File: rtl/arm2nios_pkg.sv
// Register map constants shared by the ARM-to-Nios capture block.
// Address decode and bit positions live here so the bench and RTL agree on one map.
package arm2nios_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_SEQ     = 2'd3;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;

  localparam int CTRL_IRQ_EN_BIT  = 0;
  localparam int CTRL_OVF_CLR_BIT = 1;

endpackage

// File: rtl/arm2nios_cap_fifo.sv
// Circular FIFO holding captured PIO words; storage is not reset, only pointers and count.
// A push while full is accepted only when a pop frees the head slot on the same edge.
module arm2nios_cap_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      push_data,
  output logic [31:0]      data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arm2nios_capture.sv
// Captures every change of the ARM PIO word into a FIFO readable over Avalon-MM.
// Define ARM2NIOS_CAPTURE_IRQ_EN to build the irq enable bit and the registered irq output.
module arm2nios_capture
  import arm2nios_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pio_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  logic [31:0]      prev_q;
  logic [31:0]      seq;
  logic             overflow;
  logic             capture;
  logic             pop;
  logic             push_ok;
  logic             overflow_set;
  logic             ctrl_wr;
  logic [31:0]      fifo_data;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             unused_wdata;

  assign capture      = (pio_in != prev_q);
  assign pop          = chipselect & read & (address == ADDR_DATA) & ~empty;
  assign ctrl_wr      = chipselect & ~write_n & (address == ADDR_CONTROL);
  assign push_ok      = capture & (~full | pop);
  assign overflow_set = capture & full & ~pop;
  assign unused_wdata = ^writedata;

  arm2nios_cap_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (capture),
    .pop       (pop),
    .push_data (pio_in),
    .data      (fifo_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Overflow set takes priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= '0;
      seq      <= '0;
      overflow <= 1'b0;
    end else begin
      prev_q <= pio_in;
      if (push_ok) seq <= seq + 32'd1;
      if (overflow_set)
        overflow <= 1'b1;
      else if (ctrl_wr && writedata[CTRL_OVF_CLR_BIT])
        overflow <= 1'b0;
    end
  end

`ifdef ARM2NIOS_CAPTURE_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= writedata[CTRL_IRQ_EN_BIT];
      irq <= irq_en & (~empty | overflow);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: begin
        if (!empty) readdata = fifo_data;
      end
      ADDR_STATUS: begin
        readdata[CNT_W-1:0]     = count;
        readdata[STAT_EMPTY_BIT] = empty;
        readdata[STAT_FULL_BIT]  = full;
        readdata[STAT_OVF_BIT]   = overflow;
      end
      ADDR_CONTROL: begin
`ifdef ARM2NIOS_CAPTURE_IRQ_EN
        readdata[CTRL_IRQ_EN_BIT] = irq_en;
`endif
      end
      default: readdata = seq;
    endcase
  end

endmodule

// File: tb/tb_arm2nios_capture.sv
// Self-checking bench for arm2nios_capture: directed scenarios plus random Avalon/PIO traffic
// compared against a queue-based model of the capture FIFO and register map.
module tb_arm2nios_capture;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset_n;
  logic [31:0] pio_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] mq[$];
  logic [31:0] mPrev;
  logic [31:0] mSeq;
  bit          mOvf;
  bit          mIrqEn;
  bit          mIrq;

  arm2nios_capture #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pio_in     (pio_in),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] expectedRead(input logic [1:0] addr);
    logic [31:0] r;
    r = '0;
    case (addr)
      2'd0: if (mq.size() > 0) r = mq[0];
      2'd1: begin
        r = 32'(mq.size());
        r[16] = (mq.size() == 0);
        r[17] = (mq.size() == DEPTH);
        r[18] = mOvf;
      end
      2'd2: r[0] = mIrqEn;
      default: r = mSeq;
    endcase
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    int  preSize;
    bit  preOvf;
    bit  cap;
    bit  doPop;
    bit  setOvf;
    logic [31:0] dropped;
    preSize = mq.size();
    preOvf  = mOvf;
`ifdef ARM2NIOS_CAPTURE_IRQ_EN
    mIrq = mIrqEn && (preSize != 0 || preOvf);
`else
    mIrq = 1'b0;
`endif
    cap   = (pio_in != mPrev);
    mPrev = pio_in;
    doPop = chipselect && read && address == 2'd0 && preSize > 0;
    if (doPop) dropped = mq.pop_front();
    setOvf = 1'b0;
    if (cap) begin
      if (preSize == DEPTH && !doPop) setOvf = 1'b1;
      else begin
        mq.push_back(pio_in);
        mSeq = mSeq + 32'd1;
      end
    end
    if (chipselect && !write_n && address == 2'd2) begin
`ifdef ARM2NIOS_CAPTURE_IRQ_EN
      mIrqEn = writedata[0];
`endif
      if (writedata[1]) mOvf = 1'b0;
    end
    if (setOvf) mOvf = 1'b1;
  endtask

  task automatic applyStimulus(input logic [31:0] pio, input logic [1:0] addr, input logic cs,
                               input logic rd, input logic wn, input logic [31:0] wd);
    pio_in     = pio;
    address    = addr;
    chipselect = cs;
    read       = rd;
    write_n    = wn;
    writedata  = wd;
    @(negedge clk);
    if (cs && rd) checkOutput($sformatf("read_addr%0d", addr), readdata, expectedRead(addr));
    checkOutput("irq", {31'b0, irq}, {31'b0, mIrq});
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle(input logic [31:0] pio);
    applyStimulus(pio, 2'd0, 1'b0, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic rdReg(input logic [1:0] addr);
    applyStimulus(pio_in, addr, 1'b1, 1'b1, 1'b1, 32'd0);
  endtask

  task automatic wrReg(input logic [1:0] addr, input logic [31:0] wd);
    applyStimulus(pio_in, addr, 1'b1, 1'b0, 1'b0, wd);
  endtask

  // Async reset asserted between edges; register reads are checked against fixed reset values.
  task automatic doReset(input logic [31:0] pioAtRelease);
    chipselect = 1'b0;
    read       = 1'b0;
    write_n    = 1'b1;
    reset_n    = 1'b0;
    mq.delete();
    mPrev  = '0;
    mSeq   = '0;
    mOvf   = 1'b0;
    mIrqEn = 1'b0;
    mIrq   = 1'b0;
    address = 2'd0;
    #1 checkOutput("reset_data", readdata, 32'h0);
    address = 2'd1;
    #1 checkOutput("reset_status", readdata, 32'h0001_0000);
    address = 2'd2;
    #1 checkOutput("reset_control", readdata, 32'h0);
    address = 2'd3;
    #1 checkOutput("reset_seq", readdata, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    pio_in = pioAtRelease;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    pio_in     = '0;
    address    = '0;
    chipselect = 1'b0;
    read       = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (2) @(posedge clk);
    #1;
    doReset(32'h0);

    $display("[TB] three distinct words then drain");
    idle(32'h11); idle(32'h22); idle(32'h33);
    rdReg(2'd1); rdReg(2'd3);
    repeat (3) rdReg(2'd0);
    rdReg(2'd1); rdReg(2'd0);

    $display("[TB] held word captured once");
    repeat (10) idle(32'hA5A5A5A5);
    rdReg(2'd1); rdReg(2'd3); rdReg(2'd0); rdReg(2'd1);

    $display("[TB] overflow and clear");
    for (int i = 1; i <= 9; i++) idle(32'h100 + 32'(i));
    rdReg(2'd1); rdReg(2'd3); rdReg(2'd0);
    wrReg(2'd0, 32'hFFFF_FFFF); wrReg(2'd1, 32'hFFFF_FFFF); wrReg(2'd3, 32'hFFFF_FFFF);
    rdReg(2'd1); wrReg(2'd2, 32'h2); rdReg(2'd1);

    $display("[TB] push and pop while full");
    idle(32'h200); rdReg(2'd1);
    applyStimulus(32'h201, 2'd0, 1'b1, 1'b1, 1'b1, 32'd0);
    rdReg(2'd1);
    applyStimulus(32'h202, 2'd2, 1'b1, 1'b0, 1'b0, 32'h2);
    rdReg(2'd1);
    wrReg(2'd2, 32'h2);
    repeat (9) rdReg(2'd0);
    rdReg(2'd1);

    $display("[TB] interrupt enable");
    wrReg(2'd2, 32'h1); rdReg(2'd2);
    idle(32'h300); idle(32'h300); idle(32'h300);
    rdReg(2'd0); idle(32'h300); idle(32'h300);
    wrReg(2'd2, 32'h0);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] p;
      logic [31:0] wd;
      case ($urandom_range(0, 3))
        0: p = 32'hDEAD_0000;
        1: p = 32'h0000_BEEF;
        2: p = pio_in;
        default: p = $urandom;
      endcase
      wd = {$urandom} & 32'h0000_0003;
      applyStimulus(p, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0), wd);
    end

    $display("[TB] reset with entries queued");
    wrReg(2'd2, 32'h2);
    repeat (DEPTH) rdReg(2'd0);
    for (int i = 1; i <= 5; i++) idle(32'h400 + 32'(i));
    rdReg(2'd1);
    doReset(32'h405);
    rdReg(2'd1); rdReg(2'd3); rdReg(2'd0); rdReg(2'd0); rdReg(2'd1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
